// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and baud divider helper.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam logic        IDLE_LEVEL  = 1'b1;
    localparam logic        START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_state_t;

    function automatic int unsigned calc_clk_div(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_ctl_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty and a registered fill level.
// Read data is show-ahead: rd_data always presents the head entry.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_ctl.sv
// UART transmitter: valid/ready byte input, FIFO, and 8N1 serialiser (8E1 when
// UART_TX_PARITY_EN is defined). All outputs registered except tx_ready.
module uart_tx_ctl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [7:0]                        tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic                              uart_tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int unsigned       CLK_DIV  = calc_clk_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned       CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]        BIT_LAST = 3'(DATA_BITS - 1);

    uart_state_t      state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    assign tx_ready = !fifo_full && !rst;
    assign push     = tx_valid && tx_ready;
    assign bit_end  = (baud_cnt == CNT_LAST);

    // Pop from IDLE, or at the end of STOP so the next start bit follows with no gap.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == ST_IDLE)                pop = 1'b1;
            else if (state == ST_STOP && bit_end) pop = 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            uart_tx   <= IDLE_LEVEL;
            busy      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    uart_tx  <= IDLE_LEVEL;
                    if (pop) begin
                        shift_reg <= fifo_head;
                        bit_idx   <= '0;
                        state     <= ST_START;
                        uart_tx   <= START_LEVEL;
                        busy      <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^fifo_head;
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= ST_DATA;
                        uart_tx  <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state   <= ST_PARITY;
                            uart_tx <= parity_bit;
`else
                            state   <= ST_STOP;
                            uart_tx <= IDLE_LEVEL;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            uart_tx   <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= ST_STOP;
                        uart_tx  <= IDLE_LEVEL;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_reg <= fifo_head;
                            bit_idx   <= '0;
                            state     <= ST_START;
                            uart_tx   <= START_LEVEL;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^fifo_head;
`endif
                        end else begin
                            state   <= ST_IDLE;
                            uart_tx <= IDLE_LEVEL;
                            busy    <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    uart_tx <= IDLE_LEVEL;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_ctl.md
# uart_tx_ctl

UART transmitter for the board's serial link; the sending counterpart of the `uart_rx` path that drives the segment display. It accepts bytes over a valid/ready handshake into a small synchronous FIFO. It serialises them onto `uart_tx` as 8N1 frames at a fixed baud rate derived from the 12 MHz board clock. It sits beside `display_ctl` in `top`, and application blocks (keypad, piano, debug) push status bytes through it.

## Interface
- `CLK_FREQ`, 12000000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, line rate in bit/s; `CLK_DIV = CLK_FREQ/BAUD_RATE` (integer, must be ≥ 4).
- `FIFO_DEPTH`, 16, number of byte entries; power of two, ≥ 2.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `tx_data` input 8: byte to send.
- `tx_valid` input 1: `tx_data` is valid this cycle.
- `tx_ready` output 1: FIFO can accept a byte this cycle.
- `uart_tx` output 1: serial line, idle high.
- `busy` output 1: a frame is in progress.
- `fifo_level` output `$clog2(FIFO_DEPTH+1)`: bytes currently queued, excluding the byte being shifted.

## Operation
- Handshake:
  - A byte is accepted on a rising edge where `tx_valid && tx_ready`.
  - `tx_ready = !full && !rst`.
  - `tx_valid` without `tx_ready` is ignored; nothing is dropped silently inside the block, and the upstream holds the byte.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Configuration).
  - IDLE: `uart_tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter and bit index, and go to START.
  - START: `uart_tx`=0 for CLK_DIV cycles, then go to DATA.
  - DATA: send 8 bits LSB first, each held CLK_DIV cycles. After bit 7, go to STOP (or PARITY).
  - STOP: `uart_tx`=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLK_DIV-1 and is cleared on every state change. The bit boundary is where count == CLK_DIV-1.
- `busy` = (state != IDLE).
- Simultaneous push and pop:
  - Allowed whenever not full.
  - When full, push is refused (`tx_ready`=0) even in the same cycle as a pop. `tx_ready` rises the cycle after the pop.
- `fifo_level` updates on the same edge as the push/pop. Simultaneous push and pop leaves it unchanged.
- Reset:
  - Takes effect on the next edge, including mid-frame.
  - The frame is abandoned, `uart_tx` returns to 1 immediately and the FIFO empties.
- Reset values: `uart_tx`=1, `busy`=0, `fifo_level`=0, `tx_ready`=0 while `rst` is high and 1 on the first cycle after.

## Timing
- All outputs are registered except `tx_ready` (combinational from full flag and `rst`).
- Latency, empty FIFO and IDLE, byte accepted at edge N:
  - The FIFO write lands at N.
  - The FSM pops at N+1.
  - `uart_tx` falls at edge N+1 output, i.e. visible in cycle N+2.
- Frame length: 10·CLK_DIV cycles (11·CLK_DIV with parity). Back-to-back frames are exactly contiguous.
- Throughput: one byte per frame; the FIFO absorbs bursts up to FIFO_DEPTH plus one byte in flight.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state follows DATA and transmits even parity (XOR of the 8 data bits) for CLK_DIV cycles, then goes to STOP.
  - Frame format is 8E1.
- Undefined: no PARITY state exists, DATA goes straight to STOP, and the frame is 8N1.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - `CLK_DIV` calculation function.
  - Frame constants (data bits = 8, idle level = 1).
- `uart_pkg` is shared with the receiver path.
- One sub-module, `sync_fifo` (parameterised width/depth), provides:
  - pointer wrap with an extra MSB for full/empty;
  - `level` output.
- `uart_tx_ctl` holds the handshake glue, baud counter, shift register and FSM.

## Test plan
Sim parameters: CLK_FREQ=16, BAUD_RATE=1 (CLK_DIV=16), FIFO_DEPTH=4.
- Single byte, idle: push 0x55 at cycle 10. `uart_tx` goes low in cycle 12, then bits 1,0,1,0,1,0,1,0, then stop 1, each 16 cycles. `busy` is low again after 160 cycles.
- Burst: push 0xA5, 0x3C, 0xFF, 0x00, 0x81 back-to-back.
  - `tx_ready` drops after the 5th accept (4 queued + 1 shifting).
  - Five frames appear with no idle gap.
  - `fifo_level` sequence is 0,1,2,3,4,3,…
- Full with pop: hold `tx_valid`=1 while full. `tx_ready` stays 0 on the pop edge, rises the next cycle, and exactly one byte is accepted.
- Reset mid-frame: assert `rst` for one cycle during DATA bit 3 of 0x00. `uart_tx`=1 the next cycle, `busy`=0, `fifo_level`=0, and no further frames are sent.
- Parity (`UART_TX_PARITY_EN`): send 0x07. The parity bit is 1, and the frame is 176 cycles long. Without the macro, the same byte gives a 160-cycle frame with no parity bit.
- Idle line: no pushes for 1000 cycles. `uart_tx` stays 1, `busy` stays 0, and `tx_ready` stays 1.
